lsu_uart_ctrl: RTL and testbench

Memory-stage load/store controller for the pipelined core. It steers each MEM-stage access either to data memory or to the memory-mapped UART TX/RX FIFOs, and it stalls the pipeline through `pipe_en` while an access cannot complete. It sits between the MEM pipeline register outputs and the data memory, UART TX FIFO and UART RX FIFO. It returns load data to the write-back mux.

---
 rtl/lsu_ctrl_pkg.sv | 23 ++
 rtl/lsu_addr_decode.sv | 27 ++
 rtl/lsu_uart_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lsu_uart_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the MEM-stage load/store controller.
// Holds the FSM state type, UART register offsets and status bit positions.
package lsu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DM_RD,
      TX_WAIT,
      RX_WAIT
   } state_t;

   localparam logic [7:0] OFF_TX   = 8'h00;
   localparam logic [7:0] OFF_STAT = 8'h04;
   localparam logic [7:0] OFF_RX   = 8'h08;

   localparam int unsigned STAT_TX_FULL  = 0;
   localparam int unsigned STAT_RX_AVAIL = 1;
   localparam int unsigned STAT_TX_BUSY  = 2;
   localparam int unsigned STAT_RX_ERR   = 3;

   localparam logic [31:0] RX_TIMEOUT_VAL = 32'hFFFF_FFFF;

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational address decode: data memory versus the UART register window.
// Exactly one of the outputs is high for any address.
module lsu_addr_decode
   import lsu_ctrl_pkg::*;
#(
   parameter logic [31:0] UART_BASE = 32'h8000_0000
) (
   input  logic [31:0] addr,
   output logic        is_dm,
   output logic        is_tx,
   output logic        is_stat,
   output logic        is_rx,
   output logic        is_unmapped
);

   logic in_uart;

   always_comb begin
      in_uart     = (addr[31:8] == UART_BASE[31:8]);
      is_dm       = !in_uart;
      is_tx       = in_uart && (addr[7:0] == OFF_TX);
      is_stat     = in_uart && (addr[7:0] == OFF_STAT);
      is_rx       = in_uart && (addr[7:0] == OFF_RX);
      is_unmapped = in_uart && !is_tx && !is_stat && !is_rx;
   end

endmodule

// File: rtl/lsu_uart_ctrl.sv
// MEM-stage load/store controller: steers accesses to data memory or the UART
// FIFOs and stalls the pipeline via pipe_en while an access is outstanding.
module lsu_uart_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter logic [31:0] UART_BASE  = 32'h8000_0000,
   parameter int unsigned RX_TIMEOUT = 1024,
   parameter int unsigned CNT_W      = $clog2(RX_TIMEOUT)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memrq,
   input  logic        memwq,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        pipe_en,
   output logic        dm_we,
   output logic        dm_re,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic        tx_push,
   output logic [7:0]  tx_data,
   input  logic        tx_full,
   input  logic        tx_busy,
   output logic        rx_pop,
   input  logic [7:0]  rx_data,
   input  logic        rx_empty
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RX_TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             rx_err;

   logic is_dm, is_tx, is_stat, is_rx, is_unmapped;
   logic wr, rd;
   logic timeout, stat_rd;
   logic [31:0] status;

   lsu_addr_decode #(
      .UART_BASE (UART_BASE)
   ) u_decode (
      .addr        (addr),
      .is_dm       (is_dm),
      .is_tx       (is_tx),
      .is_stat     (is_stat),
      .is_rx       (is_rx),
      .is_unmapped (is_unmapped)
   );

   assign dm_addr  = addr;
   assign dm_wdata = wdata;
   assign tx_data  = wdata[7:0];

   // A simultaneous load+store request is a store.
   assign wr = memwq;
   assign rd = memrq && !memwq;

   always_comb begin
      status                = '0;
      status[STAT_TX_FULL]  = tx_full;
      status[STAT_RX_AVAIL] = !rx_empty;
      status[STAT_TX_BUSY]  = tx_busy;
      status[STAT_RX_ERR]   = rx_err;
   end

   always_comb begin
      pipe_en = 1'b1;
      dm_we   = 1'b0;
      dm_re   = 1'b0;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      rdata   = '0;
      timeout = 1'b0;
      stat_rd = 1'b0;
      if (rst) begin
         unique case (state)
            IDLE: begin
               if (wr) begin
                  if (is_dm) begin
                     dm_we = 1'b1;
                  end else if (is_tx) begin
                     if (!tx_full) tx_push = 1'b1;
                     else          pipe_en = 1'b0;
                  end
               end else if (rd) begin
                  if (is_dm) begin
                     dm_re   = 1'b1;
                     pipe_en = 1'b0;
                  end else if (is_rx) begin
                     if (!rx_empty) begin
                        rx_pop = 1'b1;
                        rdata  = {24'b0, rx_data};
                     end else begin
                        pipe_en = 1'b0;
                     end
                  end else if (is_stat) begin
                     rdata   = status;
                     stat_rd = 1'b1;
                  end else if (is_unmapped) begin
                     rdata = '0;
                  end
               end
            end
            DM_RD: rdata = dm_rdata;
            TX_WAIT: begin
               if (tx_full) pipe_en = 1'b0;
               else         tx_push = 1'b1;
            end
            RX_WAIT: begin
               // Data arriving on the final cycle takes priority over the timeout.
               if (!rx_empty) begin
                  rx_pop = 1'b1;
                  rdata  = {24'b0, rx_data};
               end else if (cnt == CNT_MAX) begin
                  rdata   = RX_TIMEOUT_VAL;
                  timeout = 1'b1;
               end else begin
                  pipe_en = 1'b0;
               end
            end
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         rx_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (wr && is_tx && tx_full) begin
                  state <= TX_WAIT;
               end else if (rd && is_dm) begin
                  state <= DM_RD;
               end else if (rd && is_rx && rx_empty) begin
                  state <= RX_WAIT;
                  cnt   <= '0;
               end
            end
            DM_RD: state <= IDLE;
            TX_WAIT: begin
               if (!tx_full) state <= IDLE;
            end
            RX_WAIT: begin
               if (!rx_empty || cnt == CNT_MAX) state <= IDLE;
               else                             cnt   <= cnt + CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
         if (timeout)      rx_err <= 1'b1;
         else if (stat_rd) rx_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lsu_uart_ctrl.sv
// Bench for lsu_uart_ctrl: per-cycle transaction-level model plus directed
// scenarios with hand-computed latencies and data.
module tb_lsu_uart_ctrl;

   localparam logic [31:0] UB = 32'h8000_0000;
   localparam int T = 8;
   localparam int K_TX = 1, K_DM = 2, K_RX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        memrq, memwq;
   logic [31:0] addr, wdata, rdata;
   logic        pipe_en, dm_we, dm_re;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        tx_push, tx_full, tx_busy;
   logic [7:0]  tx_data, rx_data;
   logic        rx_pop, rx_empty;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   lsu_uart_ctrl #(
      .UART_BASE  (UB),
      .RX_TIMEOUT (T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .memrq    (memrq),
      .memwq    (memwq),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .pipe_en  (pipe_en),
      .dm_we    (dm_we),
      .dm_re    (dm_re),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .tx_push  (tx_push),
      .tx_data  (tx_data),
      .tx_full  (tx_full),
      .tx_busy  (tx_busy),
      .rx_pop   (rx_pop),
      .rx_data  (rx_data),
      .rx_empty (rx_empty)
   );

   // Data memory stub with one-cycle read latency.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (dm_we) mem[dm_addr[9:2]] = dm_wdata;
      dm_rdata = dm_re ? mem[dm_addr[9:2]] : 32'h0BAD_F00D;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: the access in progress (if it has stalled), stall cycles so far, sticky error.
   bit           m_busy = 1'b0;
   int           m_kind = 0;
   int           m_waited = 0;
   bit           m_err = 1'b0;
   logic [31:0]  m_mem [logic [31:0]];

   always @(negedge clk) begin
      logic        st, ld, in_uart;
      logic [7:0]  off;
      logic        e_pe, e_we, e_re, e_push, e_pop;
      logic [31:0] e_rd;
      bit          nb, ne;
      int          nk, nw;
      if (chk_en) begin
         st = memwq;
         ld = memrq && !memwq;
         in_uart = (addr[31:8] == UB[31:8]);
         off = addr[7:0];
         e_pe = 1; e_we = 0; e_re = 0; e_push = 0; e_pop = 0; e_rd = 0;
         nb = m_busy; nk = m_kind; nw = m_waited; ne = m_err;
         if (!rst) begin
            nb = 0; ne = 0;
         end else if (!m_busy) begin
            if (st && !in_uart) begin
               e_we = 1;
               m_mem[addr] = wdata;
            end else if (st && off == 8'h00) begin
               if (!tx_full) e_push = 1;
               else begin e_pe = 0; nb = 1; nk = K_TX; nw = 1; end
            end else if (ld && !in_uart) begin
               e_re = 1; e_pe = 0; nb = 1; nk = K_DM; nw = 1;
            end else if (ld && off == 8'h08) begin
               if (!rx_empty) begin e_pop = 1; e_rd = {24'b0, rx_data}; end
               else begin e_pe = 0; nb = 1; nk = K_RX; nw = 1; end
            end else if (ld && off == 8'h04) begin
               e_rd = {28'b0, m_err, tx_busy, !rx_empty, tx_full};
               ne = 0;
            end
         end else begin
            if (m_kind == K_DM) begin
               e_rd = m_mem.exists(addr) ? m_mem[addr] : 32'h0;
               nb = 0;
            end else if (m_kind == K_TX) begin
               if (tx_full) begin e_pe = 0; nw = m_waited + 1; end
               else begin e_push = 1; nb = 0; end
            end else begin
               if (!rx_empty) begin e_pop = 1; e_rd = {24'b0, rx_data}; nb = 0; end
               else if (m_waited < T) begin e_pe = 0; nw = m_waited + 1; end
               else begin e_rd = 32'hFFFF_FFFF; ne = 1; nb = 0; end
            end
         end
         check("strobes{pe,we,re,push,pop}", {27'b0, pipe_en, dm_we, dm_re, tx_push, rx_pop},
               {27'b0, e_pe, e_we, e_re, e_push, e_pop});
         check("rdata", rdata, e_rd);
         check("dm_addr", dm_addr, addr);
         check("dm_wdata", dm_wdata, wdata);
         check("tx_data", {24'b0, tx_data}, {24'b0, wdata[7:0]});
         m_busy = nb; m_kind = nk; m_waited = nw; m_err = ne;
      end
   end

   // Drives one request (caller is just after a rising edge) and runs it to completion.
   task automatic access(input logic rq, input logic wq, input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic [31:0] rd, output int we_n,
                         output int re_n, output int push_n, output int pop_n,
                         output logic [7:0] txd);
      bit done = 0;
      int guard = 0;
      memrq = rq; memwq = wq; addr = a; wdata = d;
      stalls = 0; rd = 0; we_n = 0; re_n = 0; push_n = 0; pop_n = 0; txd = 0;
      while (!done && guard < 50) begin
         @(negedge clk);
         guard++;
         we_n += int'(dm_we); re_n += int'(dm_re);
         push_n += int'(tx_push); pop_n += int'(rx_pop);
         if (tx_push) txd = tx_data;
         if (pipe_en) begin rd = rdata; done = 1; end
         else stalls++;
      end
      if (!done) check("access_bound", 32'd0, 32'd1);
      @(posedge clk); #1;
      memrq = 0; memwq = 0;
   endtask

   int          s, we_n, re_n, push_n, pop_n;
   logic [31:0] rd;
   logic [7:0]  txd;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      rst = 0; memrq = 0; memwq = 0; addr = 0; wdata = 0;
      tx_full = 0; tx_busy = 0; rx_data = 0; rx_empty = 1;
      chk_en = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_pipe_en", {31'b0, pipe_en}, 32'd1);
      check("reset_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1;

      access(0, 1, 32'h100, 32'hDEAD_BEEF, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("dm_store_stalls", s, 0);
      check("dm_store_we", we_n, 1);
      access(1, 0, 32'h100, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("dm_load_stalls", s, 1);
      check("dm_load_re", re_n, 1);
      check("dm_load_rdata", rd, 32'hDEAD_BEEF);

      tx_full = 1;
      fork
         access(0, 1, UB, 32'h0000_0041, s, rd, we_n, re_n, push_n, pop_n, txd);
         begin repeat (3) @(posedge clk); #1 tx_full = 0; end
      join
      check("tx_wait_stalls", s, 3);
      check("tx_wait_push", push_n, 1);
      check("tx_wait_data", {24'b0, txd}, 32'h41);

      fork
         access(1, 0, UB + 32'h8, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
         begin repeat (5) @(posedge clk); #1 rx_data = 8'h5A; rx_empty = 0; end
      join
      rx_empty = 1;
      check("rx_wait_stalls", s, 5);
      check("rx_wait_pop", pop_n, 1);
      check("rx_wait_rdata", rd, 32'h0000_005A);

      access(1, 0, UB + 32'h8, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("rx_timeout_stalls", s, T);
      check("rx_timeout_rdata", rd, 32'hFFFF_FFFF);
      check("rx_timeout_pop", pop_n, 0);
      access(1, 0, UB + 32'h4, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("status_err_set", rd, 32'h8);
      check("status_stalls", s, 0);
      access(1, 0, UB + 32'h4, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("status_err_clr", rd, 32'h0);

      rx_empty = 0; rx_data = 8'h33; tx_full = 1; tx_busy = 1;
      access(1, 0, UB + 32'h4, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("status_bits", rd, 32'h7);
      tx_full = 0; tx_busy = 0;
      access(1, 0, UB + 32'h8, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("rx_direct_rdata", rd, 32'h33);
      check("rx_direct_stalls", s, 0);
      rx_empty = 1;

      access(1, 1, UB, 32'h0000_0041, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("both_high_push", push_n, 1);
      check("both_high_pop", pop_n, 0);
      check("both_high_stalls", s, 0);
      access(1, 0, UB + 32'h10, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("unmapped_rdata", rd, 32'h0);
      check("unmapped_stalls", s, 0);
      access(0, 1, UB + 32'h4, 32'h1234_5678, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("stat_write_strobes", we_n + push_n + pop_n + re_n, 0);

      // Reset abandons a TX wait: set rx_err first so its clearing is visible.
      access(1, 0, UB + 32'h8, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      tx_full = 1;
      memwq = 1; addr = UB; wdata = 32'h42;
      repeat (2) @(negedge clk);
      check("rst_wait_stalled", {31'b0, pipe_en}, 32'd0);
      @(posedge clk); #1;
      rst = 0; memwq = 0; tx_full = 0;
      push_n = 0;
      repeat (2) begin @(negedge clk); push_n += int'(tx_push); end
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      push_n += int'(tx_push);
      check("rst_no_push", push_n, 0);
      check("rst_pipe_en", {31'b0, pipe_en}, 32'd1);
      @(posedge clk); #1;
      access(1, 0, UB + 32'h4, 32'h0, s, rd, we_n, re_n, push_n, pop_n, txd);
      check("rst_err_cleared", rd, 32'h0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
